// File: rtl/dram.sv
// Byte-addressed RV32 data memory: SB/SH/SW stores, combinational little-endian
// word read with address wrap-around, and the top byte exported as io_char.
module dram #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [31:0]           DIN,
  input  logic                  wren,
  input  logic [2:0]            func3,
  output logic [31:0]           DOUT,
  output logic [7:0]            io_char
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_a1;
  logic [ADDR_WIDTH-1:0] w_a2;
  logic [ADDR_WIDTH-1:0] w_a3;
  logic                  w_wr_half;
  logic                  w_wr_word;
  logic                  w_unused_f3;

  // Byte-lane addresses wrap naturally at the top of memory
  assign w_a1 = ADDR + ADDR_WIDTH'(1);
  assign w_a2 = ADDR + ADDR_WIDTH'(2);
  assign w_a3 = ADDR + ADDR_WIDTH'(3);

  // func3[2] only distinguishes unsigned loads, so it never affects a store
  assign w_wr_half   = func3[1] | func3[0];
  assign w_wr_word   = func3[1];
  assign w_unused_f3 = func3[2];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (wren) begin
      r_mem[ADDR] <= DIN[7:0];
      if (w_wr_half) begin
        r_mem[w_a1] <= DIN[15:8];
      end
      if (w_wr_word) begin
        r_mem[w_a2] <= DIN[23:16];
        r_mem[w_a3] <= DIN[31:24];
      end
    end
  end

  assign DOUT    = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[ADDR]};
  assign io_char = r_mem[DEPTH-1];

endmodule

// File: tb/tb_dram.sv
// Directed self-checking bench for dram: reset, narrow/wide stores, wrap-around,
// write-enable/clear priority and read-during-write ordering.
module tb_dram;

  logic        clock;
  logic        clear;
  logic [7:0]  ADDR;
  logic [31:0] DIN;
  logic        wren;
  logic [2:0]  func3;
  logic [31:0] DOUT;
  logic [7:0]  io_char;

  int n_total;
  int n_pass;

  dram #(.ADDR_WIDTH(8)) dut (
    .clock   (clock),
    .clear   (clear),
    .ADDR    (ADDR),
    .DIN     (DIN),
    .wren    (wren),
    .func3   (func3),
    .DOUT    (DOUT),
    .io_char (io_char)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    ADDR = a;
    #1;
    check(tag, DOUT, exp);
  endtask

  task automatic store(input logic [7:0] a, input logic [31:0] d, input logic [2:0] f);
    ADDR  = a;
    DIN   = d;
    func3 = f;
    wren  = 1'b1;
    @(posedge clock);
    #1;
    wren  = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    clear = 1'b0; ADDR = '0; DIN = '0; wren = 1'b0; func3 = 3'b000;

    // Reset and read
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    read_chk("rst_a0",   8'd0,   32'h0000_0000);
    read_chk("rst_a100", 8'd100, 32'h0000_0000);
    read_chk("rst_a252", 8'd252, 32'h0000_0000);
    check("rst_io", 32'(io_char), 32'h0000_0000);

    // Word store and byte-lane reads
    store(8'd8, 32'hDEAD_BEEF, 3'b010);
    read_chk("sw_a8",  8'd8,  32'hDEAD_BEEF);
    read_chk("sw_a9",  8'd9,  32'h00DE_ADBE);
    read_chk("sw_a11", 8'd11, 32'h0000_00DE);

    // Narrow stores over an existing word
    store(8'd16, 32'h1122_3344, 3'b010);
    store(8'd17, 32'hAAAA_AA55, 3'b000);
    read_chk("sb_a16", 8'd16, 32'h1122_5544);
    store(8'd18, 32'hFFFF_6677, 3'b001);
    read_chk("sh_a16", 8'd16, 32'h6677_5544);

    // Unsigned-load encodings still store by func3[1:0]
    store(8'd64, 32'hFFFF_A1B2, 3'b101);
    read_chk("f3_101", 8'd64, 32'h0000_A1B2);
    store(8'd72, 32'h9988_7766, 3'b100);
    read_chk("f3_100", 8'd72, 32'h0000_0066);

    // Wrap-around and character output
    store(8'd254, 32'h0403_0201, 3'b010);
    read_chk("wrap_a254", 8'd254, 32'h0403_0201);
    read_chk("wrap_a0",   8'd0,   32'h0000_0403);
    check("wrap_io", 32'(io_char), 32'h0000_0002);
    store(8'd255, 32'h0000_0041, 3'b000);
    check("sb_io", 32'(io_char), 32'h0000_0041);
    store(8'd255, 32'h0000_BEEF, 3'b001);
    check("sh_wrap_io", 32'(io_char), 32'h0000_00EF);
    read_chk("sh_wrap_a0", 8'd0, 32'h0000_04BE);

    // Write enable and clear priority
    ADDR = 8'd32; DIN = 32'h1234_5678; func3 = 3'b010; wren = 1'b0;
    @(posedge clock); #1;
    check("wren0_a32", DOUT, 32'h0000_0000);
    wren = 1'b1; clear = 1'b1;
    @(posedge clock); #1;
    check("clr_pri_a32", DOUT, 32'h0000_0000);
    check("clr_io", 32'(io_char), 32'h0000_0000);
    clear = 1'b0;
    @(posedge clock); #1;
    wren = 1'b0;
    check("wr_a32", DOUT, 32'h1234_5678);
    read_chk("clr_a8",   8'd8,   32'h0000_0000);
    read_chk("clr_a254", 8'd254, 32'h0000_0000);

    // Read during write: old data before the edge, new data after it
    @(negedge clock);
    ADDR = 8'd40; DIN = 32'hCAFE_F00D; func3 = 3'b010; wren = 1'b1;
    #4;
    check("rdw_before", DOUT, 32'h0000_0000);
    @(posedge clock); #1;
    wren = 1'b0;
    check("rdw_after", DOUT, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
